// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_div_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial subtract,
// keep the difference when it did not borrow.
module div_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  // Partial remainder is WIDTH+1 bits so the borrow of the trial subtract lands in the sign bit.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Shift, trial subtract, select (restore) the result.
  always_comb begin
    shifted = {rem_i, bit_i};
    trial   = shifted - {1'b0, divisor_i};
    qbit_o  = ~trial[WIDTH];
    rem_o   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_div.sv
// Sequential unsigned restoring divider, one quotient bit per clock, MSB first.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             dbz_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;   // dividend bits shift out MSB first, quotient bits shift in
  logic [WIDTH-1:0] dsr_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] rem_d;
  logic             qbit;
  logic [WIDTH-1:0] dvd_d;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[WIDTH-1]),
    .divisor_i (dsr_q),
    .rem_o     (rem_d),
    .qbit_o    (qbit)
  );

  assign dvd_d = {dvd_q[WIDTH-2:0], qbit};

  // Control FSM and datapath; results publish only on the transition into DONE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      dbz_o       <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      cnt_q       <= '0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            dvd_q <= dividend_i;
            dsr_q <= divisor_i;
            rem_q <= '0;
            cnt_q <= '0;
            if (divisor_i == '0) begin
              // Division by zero completes immediately without iterating.
              state_q     <= DONE;
              busy_o      <= 1'b0;
              done_o      <= 1'b1;
              dbz_o       <= 1'b1;
              quotient_o  <= '1;
              remainder_o <= dividend_i;
            end else begin
              state_q <= CALC;
              busy_o  <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
            busy_o  <= 1'b0;
          end
        end
        CALC: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q     <= DONE;
            busy_o      <= 1'b0;
            done_o      <= 1'b1;
            dbz_o       <= 1'b0;
            quotient_o  <= dvd_d;
            remainder_o <= rem_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// Bench for seq_div: directed scenarios with literal results plus randomized
// traffic checked every cycle against a transaction-level model.
module tb_seq_div;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dvd = '0;
  logic [W-1:0] dsr = '0;
  logic         busy, done, dbz;
  logic [W-1:0] quo, rem;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  seq_div #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .dividend_i  (dvd),
    .divisor_i   (dsr),
    .busy_o      (busy),
    .done_o      (done),
    .quotient_o  (quo),
    .remainder_o (rem),
    .dbz_o       (dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an accepted request yields a/b, a%b after W busy cycles.
  int           m_left = 0;
  bit           m_done = 1'b0;
  bit           m_busy = 1'b0;
  bit           m_dbz = 1'b0;
  logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;

  always @(posedge clk) begin
    int l;
    bit d, dz;
    logic [W-1:0] q, r, pq, pr;
    l = m_left; d = 1'b0; dz = m_dbz; q = m_q; r = m_r; pq = p_q; pr = p_r;
    if (rst) begin
      l = 0; dz = 1'b0; q = '0; r = '0;
    end else if (l > 0) begin
      l = l - 1;
      if (l == 0) begin
        d = 1'b1; q = pq; r = pr; dz = 1'b0;
      end
    end else if (start) begin
      if (dsr == '0) begin
        d = 1'b1; q = '1; r = dvd; dz = 1'b1;
      end else begin
        pq = dvd / dsr; pr = dvd % dsr; l = W;
      end
    end
    m_left <= l; m_done <= d; m_busy <= (l > 0); m_dbz <= dz;
    m_q <= q; m_r <= r; p_q <= pq; p_r <= pr;
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(m_done));
      chk("dbz", 64'(dbz), 64'(m_dbz));
      chk("quotient", 64'(quo), 64'(m_q));
      chk("remainder", 64'(rem), 64'(m_r));
    end
  end

  // Present one request for a single cycle; returns just after the accepting edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; dvd = a; dsr = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Edges after the accepting edge until done_o is seen (bounded).
  task automatic wait_done(output int edges);
    edges = 0;
    while (!done && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    if (!done) chk("done_timeout", 64'(done), 64'd1);
  endtask

  task automatic chk_result(input string tag, input int q, input int r, input int z);
    chk({tag, "_q"}, 64'(quo), 64'(q));
    chk({tag, "_r"}, 64'(rem), 64'(r));
    chk({tag, "_dbz"}, 64'(dbz), 64'(z));
  endtask

  initial begin
    int e, bcnt, dcnt;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_q", 64'(quo), 64'd0);
    chk("rst_r", 64'(rem), 64'd0);
    chk("rst_dbz", 64'(dbz), 64'd0);

    // 100/7: done_o after W edges.
    start_op(8'd100, 8'd7);
    wait_done(e);
    chk("lat_100_7", 64'(e), 64'd8);
    chk_result("d100_7", 14, 2, 0);

    // 5/0: done_o in the cycle right after the start cycle.
    start_op(8'd5, 8'd0);
    wait_done(e);
    chk("lat_dbz", 64'(e), 64'd0);
    chk_result("d5_0", 255, 5, 1);

    start_op(8'd255, 8'd1);
    wait_done(e);
    chk_result("d255_1", 255, 0, 0);
    start_op(8'd3, 8'd10);
    wait_done(e);
    chk_result("d3_10", 0, 3, 0);

    // 200/9 with a start pulse during CALC that must be ignored.
    start_op(8'd200, 8'd9);
    e = 0; bcnt = 0;
    while (!done && e < 40) begin
      if (busy) bcnt++;
      if (e == 3) begin start = 1'b1; dvd = 8'd1; dsr = 8'd1; end
      else start = 1'b0;
      @(negedge clk);
      e++;
    end
    start = 1'b0;
    chk("lat_200_9", 64'(e), 64'd8);
    chk("busy_cycles", 64'(bcnt), 64'd8);
    chk_result("d200_9", 22, 2, 0);

    // Reset in the middle of 77/5 abandons it.
    start_op(8'd77, 8'd5);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk_result("abort", 0, 0, 0);
    dcnt = 0;
    repeat (12) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    chk("abort_no_done", 64'(dcnt), 64'd0);
    start_op(8'd77, 8'd5);
    wait_done(e);
    chk_result("d77_5", 15, 2, 0);

    // Back-to-back: start held through DONE.
    @(negedge clk);
    start = 1'b1; dvd = 8'd50; dsr = 8'd6;
    @(negedge clk);
    dvd = 8'd9; dsr = 8'd4;
    wait_done(e);
    chk("lat_50_6", 64'(e), 64'd8);
    chk_result("d50_6", 8, 2, 0);
    @(negedge clk);
    start = 1'b0;
    e = 1;
    while (!done && e < 40) begin
      @(negedge clk);
      e++;
    end
    chk("b2b_spacing", 64'(e), 64'd9);
    chk_result("d9_4", 2, 1, 0);

    // Random traffic, including zero divisors, held starts and rare resets.
    repeat (3000) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      dvd = W'($urandom);
      dsr = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      rst = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (12) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
